// File: rtl/ac_pkg.sv
// Shared encodings and default timing for the air-conditioning controller slice.
// Used by the thermostat controller, the actuator sequencer and their benches.
package ac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FAN_PRE  = 3'd1,
    ST_HEAT     = 3'd2,
    ST_COOL     = 3'd3,
    ST_FAN_POST = 3'd4,
    ST_LOCKOUT  = 3'd5,
    ST_FAULT    = 3'd6
  } ac_state_e;

  localparam int DEF_CNT_W     = 5;
  localparam int DEF_FAN_LEAD  = 2;
  localparam int DEF_MIN_ON    = 8;
  localparam int DEF_FAN_TRAIL = 4;
  localparam int DEF_MIN_OFF   = 6;

endpackage

// File: rtl/ac_dwell_timer.sv
// Dwell counter for the actuator sequencer: clears on state entry, counts up,
// saturates at all-ones and flags when it reaches the selected limit.
module ac_dwell_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit_m1,
  output logic [CNT_W-1:0] cnt,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt     = cnt_q;
  assign expired = (cnt_q == limit_m1);

endmodule

// File: rtl/ac_actuator_seq.sv
// Heater/compressor/fan sequencer with fan lead/trail, minimum run and lockout.
// Build option AC_FAULT_LATCH_EN latches a sticky fault on simultaneous heat+cool demand.
module ac_actuator_seq
  import ac_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int FAN_LEAD  = DEF_FAN_LEAD,
  parameter int MIN_ON    = DEF_MIN_ON,
  parameter int FAN_TRAIL = DEF_FAN_TRAIL,
  parameter int MIN_OFF   = DEF_MIN_OFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       heating,
  input  logic       cooling,
  output logic       heater_on,
  output logic       compressor_on,
  output logic       fan_on,
  output logic [2:0] state,
  output logic       fault
);

  localparam logic [CNT_W-1:0] LEAD_M1  = CNT_W'(FAN_LEAD - 1);
  localparam logic [CNT_W-1:0] ON_M1    = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] TRAIL_M1 = CNT_W'(FAN_TRAIL - 1);
  localparam logic [CNT_W-1:0] OFF_M1   = CNT_W'(MIN_OFF - 1);

  ac_state_e        state_q, state_d;
  logic             mode_q;
  logic             heater_q, comp_q, fan_q;
  logic [CNT_W-1:0] cnt, limit_m1;
  logic             expired, dwell_clr, demand;

  assign demand = heating ^ cooling;

  // Limit for the single shared timer follows the state being timed.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    limit_m1 = '1;
    case (state_q)
      ST_FAN_PRE:      limit_m1 = LEAD_M1;
      ST_HEAT,ST_COOL: limit_m1 = ON_M1;
      ST_FAN_POST:     limit_m1 = TRAIL_M1;
      ST_LOCKOUT:      limit_m1 = OFF_M1;
      default:         limit_m1 = '1;
    endcase
  end

  ac_dwell_timer #(.CNT_W(CNT_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (dwell_clr),
    .limit_m1 (limit_m1),
    .cnt      (cnt),
    .expired  (expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (demand) state_d = ST_FAN_PRE;
      ST_FAN_PRE: begin
        if (!demand)      state_d = ST_FAN_POST;
        else if (expired) state_d = mode_q ? ST_HEAT : ST_COOL;
      end
      ST_HEAT:     if (!heating && cnt >= ON_M1) state_d = ST_FAN_POST;
      ST_COOL:     if (!cooling && cnt >= ON_M1) state_d = ST_FAN_POST;
      ST_FAN_POST: if (expired) state_d = ST_LOCKOUT;
      ST_LOCKOUT:  if (expired) state_d = ST_IDLE;
`ifdef AC_FAULT_LATCH_EN
      ST_FAULT:    state_d = ST_FAULT;
`endif
      default:     state_d = ST_IDLE;
    endcase
`ifdef AC_FAULT_LATCH_EN
    if (heating && cooling) state_d = ST_FAULT;
`endif
  end

  assign dwell_clr = (state_d != state_q);

  // Actuator drives are decoded from the next state so they are registered
  // alongside it; heater and compressor can never be on together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= 1'b0;
      heater_q <= 1'b0;
      comp_q   <= 1'b0;
      fan_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      if (state_q == ST_IDLE && state_d == ST_FAN_PRE) mode_q <= heating;
      heater_q <= (state_d == ST_HEAT);
      comp_q   <= (state_d == ST_COOL);
      fan_q    <= (state_d == ST_FAN_PRE) || (state_d == ST_HEAT) ||
                  (state_d == ST_COOL)    || (state_d == ST_FAN_POST);
    end
  end

`ifdef AC_FAULT_LATCH_EN
  logic fault_q;

  always_ff @(posedge clk) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= (state_d == ST_FAULT);
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign state         = state_q;
  assign heater_on     = heater_q;
  assign compressor_on = comp_q;
  assign fan_on        = fan_q;

endmodule

// File: tb/tb_ac_actuator_seq.sv
// Scoreboard bench for ac_actuator_seq: directed scenarios plus random demand,
// each cycle's expected outputs come from a phase/elapsed-time reference model.
module tb_ac_actuator_seq;
  import ac_pkg::*;

  localparam int CNT_W     = DEF_CNT_W;
  localparam int FAN_LEAD  = DEF_FAN_LEAD;
  localparam int MIN_ON    = DEF_MIN_ON;
  localparam int FAN_TRAIL = DEF_FAN_TRAIL;
  localparam int MIN_OFF   = DEF_MIN_OFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       heating = 1'b0;
  logic       cooling = 1'b0;
  logic       heater_on, compressor_on, fan_on, fault;
  logic [2:0] state;

  ac_actuator_seq #(
    .CNT_W(CNT_W), .FAN_LEAD(FAN_LEAD), .MIN_ON(MIN_ON),
    .FAN_TRAIL(FAN_TRAIL), .MIN_OFF(MIN_OFF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .heating       (heating),
    .cooling       (cooling),
    .heater_on     (heater_on),
    .compressor_on (compressor_on),
    .fan_on        (fan_on),
    .state         (state),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       heat;
    logic       comp;
    logic       fan;
    logic       flt;
  } obs_t;

  obs_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: which phase the plant is in and how many whole cycles
  // have been spent there; phase changes are decided from elapsed time.
  ac_state_e m_phase   = ST_IDLE;
  int        m_elapsed = 0;
  logic      m_heat_mode = 1'b0;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got state=%0d heater=%b comp=%b fan=%b fault=%b, expected state=%0d heater=%b comp=%b fan=%b fault=%b",
               name, $time, act.st, act.heat, act.comp, act.fan, act.flt,
               exp.st, exp.heat, exp.comp, exp.fan, exp.flt);
    end
  endtask

  task automatic model_step(input logic r, input logic h, input logic c, output obs_t o);
    ac_state_e nxt;
    int        in_state;
    logic      want;
    want     = (h != c);
    in_state = m_elapsed + 1;
    nxt      = m_phase;
    if (!r) begin
      nxt         = ST_IDLE;
      m_heat_mode = 1'b0;
    end else begin
      case (m_phase)
        ST_IDLE: if (want) begin
          nxt         = ST_FAN_PRE;
          m_heat_mode = h;
        end
        ST_FAN_PRE: begin
          if (!want)                  nxt = ST_FAN_POST;
          else if (in_state == FAN_LEAD) nxt = m_heat_mode ? ST_HEAT : ST_COOL;
        end
        ST_HEAT:     if (!h && in_state >= MIN_ON) nxt = ST_FAN_POST;
        ST_COOL:     if (!c && in_state >= MIN_ON) nxt = ST_FAN_POST;
        ST_FAN_POST: if (in_state == FAN_TRAIL) nxt = ST_LOCKOUT;
        ST_LOCKOUT:  if (in_state == MIN_OFF)   nxt = ST_IDLE;
        default:     nxt = m_phase;
      endcase
`ifdef AC_FAULT_LATCH_EN
      if (h && c) nxt = ST_FAULT;
`endif
    end
    if (!r || nxt != m_phase) m_elapsed = 0;
    else                      m_elapsed = m_elapsed + 1;
    m_phase = nxt;
    o.st   = m_phase;
    o.heat = (m_phase == ST_HEAT);
    o.comp = (m_phase == ST_COOL);
    o.fan  = (m_phase == ST_FAN_PRE) || (m_phase == ST_HEAT) ||
             (m_phase == ST_COOL) || (m_phase == ST_FAN_POST);
    o.flt  = (m_phase == ST_FAULT);
  endtask

  task automatic drive(input logic r, input logic h, input logic c, input int n);
    obs_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst_n   = r;
      heating = h;
      cooling = c;
      model_step(r, h, c, e);
      sb_q.push_back(e);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare just after each edge.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("outputs", {state, heater_on, compressor_on, fan_on, fault}, e);
      end
    end
  end

  initial begin
    int r, len;
    // Reset held with heat demand, then released into a 20-cycle heat call.
    drive(1'b0, 1'b1, 1'b0, 2);
    drive(1'b1, 1'b1, 1'b0, 20);
    drive(1'b1, 1'b0, 1'b0, 20);
    // Heat demand dropped 3 cycles after HEAT entry: minimum run holds heater.
    drive(1'b1, 1'b1, 1'b0, 6);
    drive(1'b1, 1'b0, 1'b0, 25);
    // Single-cycle heat pulse.
    drive(1'b1, 1'b1, 1'b0, 1);
    drive(1'b1, 1'b0, 1'b0, 20);
    // Cooling raised during trail/lockout is served only after IDLE.
    drive(1'b1, 1'b1, 1'b0, 12);
    drive(1'b1, 1'b0, 1'b0, 8);
    drive(1'b1, 1'b0, 1'b1, 25);
    drive(1'b1, 1'b0, 1'b0, 25);
    // Both demands while cooling.
    drive(1'b1, 1'b0, 1'b1, 5);
    drive(1'b1, 1'b1, 1'b1, 12);
    drive(1'b1, 1'b0, 1'b0, 20);
    // Reset mid-operation drops actuators immediately.
    drive(1'b0, 1'b0, 1'b0, 2);
    drive(1'b1, 1'b0, 1'b1, 6);
    drive(1'b0, 1'b0, 1'b1, 1);
    drive(1'b1, 1'b0, 1'b0, 15);
    // Random demand segments with occasional resets.
    for (int i = 0; i < 150; i++) begin
      r   = int'($urandom_range(0, 99));
      len = int'($urandom_range(1, 24));
      if (r < 3)       drive(1'b0, 1'b0, 1'b0, int'($urandom_range(1, 2)));
      else if (r < 8)  drive(1'b1, 1'b1, 1'b1, len);
      else if (r < 40) drive(1'b1, 1'b1, 1'b0, len);
      else if (r < 70) drive(1'b1, 1'b0, 1'b1, len);
      else             drive(1'b1, 1'b0, 1'b0, len);
    end
    drive(1'b1, 1'b0, 1'b0, 2);
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries never compared, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
